// File: rtl/mmh_rotate_sweep_if.sv
// mmh_rotate_sweep_if: block input and rotated-pattern output handshakes of the rotation sweep engine
interface mmh_rotate_sweep_if #(
  parameter int NSEG  = 16,
  parameter int SEG_W = 64,
  parameter int PAD_W = 192,
  parameter int KW    = 5
);
  logic                    in_valid;
  logic                    in_ready;
  logic [NSEG*SEG_W-1:0]   data_in;
  logic [KW-1:0]           k_count;
  logic                    out_valid;
  logic                    out_ready;
  logic [NSEG*PAD_W-1:0]   out_data;
  logic [KW-1:0]           out_k;
  logic                    out_last;
  modport master (output in_valid, data_in, k_count, out_ready,
                  input  in_ready, out_valid, out_data, out_k, out_last);
  modport slave  (input  in_valid, data_in, k_count, out_ready,
                  output in_ready, out_valid, out_data, out_k, out_last);
endinterface

// File: rtl/mmh_rotate_sweep.sv
// mmh_rotate_sweep: zero-pads NSEG segments and emits K patterns, segment n rotated by (k*n*STEP) mod PAD_W
// Optional MMH_ROT_DIR_EN adds a dir port selecting right rotation.
module mmh_rotate_sweep #(
  parameter int NSEG  = 16,
  parameter int SEG_W = 64,
  parameter int PAD_W = 192,
  parameter int STEP  = 12,
  parameter int KMAX  = 16,
  localparam int KW   = $clog2(KMAX + 1),
  localparam int AW   = $clog2(PAD_W)
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
`ifdef MMH_ROT_DIR_EN
  input  logic dir,
`endif
  mmh_rotate_sweep_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [AW:0] PW = (AW+1)'(PAD_W);
  state_t state, state_nx;
  logic [NSEG*SEG_W-1:0] seg_q;
  logic [NSEG*PAD_W-1:0] rot_all;
  logic [KW-1:0] k_max, k_q, k_clamp;
  logic last, accept, step;
`ifdef MMH_ROT_DIR_EN
  logic dir_q;
`else
  localparam logic dir_q = 1'b0;
`endif
  assign last    = k_q == k_max - KW'(1);
  assign accept  = state == IDLE && bus.in_valid && !flush;
  assign step    = state == RUN && bus.out_ready && !last && !flush;
  assign k_clamp = (bus.k_count == '0 || bus.k_count > KW'(KMAX)) ? KW'(KMAX) : bus.k_count;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = flush ? IDLE :
               state == IDLE ? (bus.in_valid ? RUN : IDLE) :
               (bus.out_ready && last) ? IDLE : RUN;
  always_comb begin
    bus.in_ready  = state == IDLE;
    bus.out_valid = state == RUN;
    bus.out_k     = state == RUN ? k_q : '0;
    bus.out_last  = state == RUN && last;
    bus.out_data  = state == RUN ? rot_all : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      seg_q <= '0;
      k_max <= '0;
      k_q   <= '0;
`ifdef MMH_ROT_DIR_EN
      dir_q <= 1'b0;
`endif
    end else if (accept) begin
      seg_q <= bus.data_in;
      k_max <= k_clamp;
      k_q   <= '0;
`ifdef MMH_ROT_DIR_EN
      dir_q <= dir;
`endif
    end else if (step) k_q <= k_q + KW'(1);
  // Per-segment rotation amount advances by a constant increment with a single conditional wrap.
  for (genvar n = 0; n < NSEG; n++) begin : g_seg
    localparam logic [AW:0] D = (AW+1)'((n * STEP) % PAD_W);
    logic [AW-1:0] amt;
    logic [AW:0] sum;
    logic [2*PAD_W-1:0] dbl, sl, sr;
    assign sum = {1'b0, amt} + D;
    always_ff @(posedge clk or posedge rst)
      if (rst) amt <= '0;
      else if (accept) amt <= '0;
      else if (step) amt <= sum >= PW ? AW'(sum - PW) : sum[AW-1:0];
    // Doubling the word makes a zero amount an exact identity with no full-width shift term.
    assign dbl = {2{PAD_W'(seg_q[n*SEG_W +: SEG_W])}};
    assign sl  = dbl << amt;
    assign sr  = dbl >> amt;
    assign rot_all[n*PAD_W +: PAD_W] = dir_q ? sr[PAD_W-1:0] : sl[2*PAD_W-1:PAD_W];
  end
endmodule

// File: tb/tb_mmh_rotate_sweep.sv
// tb_mmh_rotate_sweep: directed checks of the rotation sweep engine with hand-computed expectations
module tb_mmh_rotate_sweep;
  localparam int NSEG = 16, SEG_W = 64, PAD_W = 192, KW = 5;
  localparam logic [SEG_W-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
`ifdef MMH_ROT_DIR_EN
  logic dir = 1'b0;
`endif
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  mmh_rotate_sweep_if #(.NSEG(NSEG), .SEG_W(SEG_W), .PAD_W(PAD_W), .KW(KW)) bus();
  mmh_rotate_sweep dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
`ifdef MMH_ROT_DIR_EN
    .dir(dir),
`endif
    .bus(bus)
  );
  function automatic logic [PAD_W-1:0] rot_exp(input logic [SEG_W-1:0] s, input int a, input bit r);
    logic [PAD_W-1:0] x, y;
    x = PAD_W'(s);
    y = '0;
    for (int i = 0; i < PAD_W; i++)
      if (r) y[i] = x[(i + a) % PAD_W];
      else y[(i + a) % PAD_W] = x[i];
    return y;
  endfunction
  task automatic test_reset;
    #2;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.out_data !== '0) begin bad++; $display("FAIL reset out_data: got %h want 0", bus.out_data); end
    total++; if (bus.out_k !== '0 || bus.out_last !== 1'b0) begin bad++; $display("FAIL reset out_k/last: got %0d/%b want 0/0", bus.out_k, bus.out_last); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset in_ready: got %b want 1", bus.in_ready); end
  endtask
  task automatic test_single_bit;
    bus.data_in = {NSEG{64'h1}}; bus.k_count = 5'd2; bus.in_valid = 1'b1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL single in_ready: got %b want 1", bus.in_ready); end
    @(negedge clk); bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1 || bus.out_k !== 5'd0 || bus.out_last !== 1'b0) begin bad++; $display("FAIL single k0 ctl: got v=%b k=%0d l=%b want 1/0/0", bus.out_valid, bus.out_k, bus.out_last); end
    for (int n = 0; n < NSEG; n++) begin
      total++; if (bus.out_data[n*PAD_W +: PAD_W] !== 192'h1) begin bad++; $display("FAIL single k0 seg%0d: got %h want 1", n, bus.out_data[n*PAD_W +: PAD_W]); end
    end
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b1 || bus.out_k !== 5'd1 || bus.out_last !== 1'b1) begin bad++; $display("FAIL single k1 ctl: got v=%b k=%0d l=%b want 1/1/1", bus.out_valid, bus.out_k, bus.out_last); end
    for (int n = 0; n < NSEG; n++) begin
      total++; if (bus.out_data[n*PAD_W +: PAD_W] !== (192'h1 << (12 * n))) begin bad++; $display("FAIL single k1 seg%0d: got %h want %h", n, bus.out_data[n*PAD_W +: PAD_W], 192'h1 << (12 * n)); end
    end
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL single end: got rdy=%b v=%b want 1/0", bus.in_ready, bus.out_valid); end
  endtask
  task automatic test_full_sweep;
    bus.data_in = '0; bus.data_in[15*SEG_W +: SEG_W] = ONES; bus.k_count = 5'd0; bus.in_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); bus.in_valid = 1'b0;
      total++; if (bus.out_valid !== 1'b1 || bus.out_k !== KW'(k) || bus.out_last !== (k == 15)) begin bad++; $display("FAIL sweep ctl k%0d: got v=%b k=%0d l=%b", k, bus.out_valid, bus.out_k, bus.out_last); end
      total++; if (bus.out_data[15*PAD_W +: PAD_W] !== rot_exp(ONES, (k * 180) % 192, 1'b0)) begin bad++; $display("FAIL sweep seg15 k%0d: got %h want %h", k, bus.out_data[15*PAD_W +: PAD_W], rot_exp(ONES, (k * 180) % 192, 1'b0)); end
      total++; if (bus.out_data[0 +: PAD_W] !== '0) begin bad++; $display("FAIL sweep seg0 k%0d: got %h want 0", k, bus.out_data[0 +: PAD_W]); end
      if (k == 1) begin
        total++; if (bus.out_data[15*PAD_W +: PAD_W] !== {12'hFFF, 128'h0, 52'hF_FFFF_FFFF_FFFF}) begin bad++; $display("FAIL sweep wrap k1: got %h", bus.out_data[15*PAD_W +: PAD_W]); end
      end
      if (k == 15) begin
        total++; if (bus.out_data[15*PAD_W +: PAD_W] !== (192'hFFFF_FFFF_FFFF_FFFF << 12)) begin bad++; $display("FAIL sweep k15 amt12: got %h", bus.out_data[15*PAD_W +: PAD_W]); end
      end
    end
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL sweep end out_valid: got %b want 0", bus.out_valid); end
  endtask
  task automatic test_backpressure;
    logic [NSEG*PAD_W-1:0] snap;
    for (int n = 0; n < NSEG; n++) bus.data_in[n*SEG_W +: SEG_W] = SEG_W'(n + 1);
    bus.k_count = 5'd8; bus.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); bus.in_valid = 1'b0;
      total++; if (bus.out_k !== KW'(k)) begin bad++; $display("FAIL bp pre k: got %0d want %0d", bus.out_k, k); end
    end
    snap = bus.out_data; bus.out_ready = 1'b0;
    total++; if (bus.out_data[5*PAD_W +: PAD_W] !== rot_exp(64'd6, 180, 1'b0)) begin bad++; $display("FAIL bp k3 seg5: got %h want %h", bus.out_data[5*PAD_W +: PAD_W], rot_exp(64'd6, 180, 1'b0)); end
    repeat (5) begin
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b1 || bus.out_k !== 5'd3 || bus.out_last !== 1'b0 || bus.out_data !== snap) begin bad++; $display("FAIL bp hold: got v=%b k=%0d l=%b data_changed=%b want 1/3/0/0", bus.out_valid, bus.out_k, bus.out_last, bus.out_data !== snap); end
    end
    bus.out_ready = 1'b1;
    for (int k = 4; k < 8; k++) begin
      @(negedge clk);
      total++; if (bus.out_k !== KW'(k) || bus.out_last !== (k == 7)) begin bad++; $display("FAIL bp resume: got k=%0d l=%b want %0d", bus.out_k, bus.out_last, k); end
    end
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp end out_valid: got %b want 0", bus.out_valid); end
  endtask
  task automatic test_back_to_back;
    bus.data_in = {NSEG{64'h5}}; bus.k_count = 5'd1; bus.in_valid = 1'b1;
    @(negedge clk); bus.data_in = {NSEG{64'h9}};
    total++; if (bus.out_valid !== 1'b1 || bus.out_last !== 1'b1 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL b2b run: got v=%b l=%b rdy=%b want 1/1/0", bus.out_valid, bus.out_last, bus.in_ready); end
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b bubble: got v=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready); end
    @(negedge clk); bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1 || bus.out_k !== 5'd0 || bus.out_data[3*PAD_W +: PAD_W] !== 192'h9) begin bad++; $display("FAIL b2b second: got v=%b k=%0d seg3=%h want 1/0/9", bus.out_valid, bus.out_k, bus.out_data[3*PAD_W +: PAD_W]); end
    @(negedge clk);
  endtask
  task automatic test_flush;
    bus.data_in = {NSEG{64'h8000_0000_0000_0001}}; bus.k_count = 5'd16; bus.in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); bus.in_valid = 1'b0;
    end
    total++; if (bus.out_k !== 5'd7) begin bad++; $display("FAIL flush pre k: got %0d want 7", bus.out_k); end
    flush = 1'b1; bus.in_valid = 1'b1; bus.data_in = {NSEG{64'h3}}; bus.k_count = 5'd3;
    @(negedge clk); flush = 1'b0; bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_k !== 5'd0 || bus.out_data !== '0) begin bad++; $display("FAIL flush idle: got v=%b rdy=%b k=%0d want 0/1/0", bus.out_valid, bus.in_ready, bus.out_k); end
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush accepted: got v=%b want 0", bus.out_valid); end
    bus.in_valid = 1'b1;
    @(negedge clk); bus.in_valid = 1'b0;
    total++; if (bus.out_k !== 5'd0 || bus.out_data[2*PAD_W +: PAD_W] !== 192'h3) begin bad++; $display("FAIL flush new k0: got k=%0d seg2=%h want 0/3", bus.out_k, bus.out_data[2*PAD_W +: PAD_W]); end
    @(negedge clk);
    total++; if (bus.out_k !== 5'd1 || bus.out_data[2*PAD_W +: PAD_W] !== (192'h3 << 24)) begin bad++; $display("FAIL flush new k1: got k=%0d seg2=%h", bus.out_k, bus.out_data[2*PAD_W +: PAD_W]); end
    @(negedge clk);
    total++; if (bus.out_last !== 1'b1 || bus.out_data[2*PAD_W +: PAD_W] !== (192'h3 << 48)) begin bad++; $display("FAIL flush new k2: got l=%b seg2=%h", bus.out_last, bus.out_data[2*PAD_W +: PAD_W]); end
    @(negedge clk);
  endtask
  task automatic test_reset_mid;
    bus.data_in = {NSEG{ONES}}; bus.k_count = 5'd0; bus.in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); bus.in_valid = 1'b0;
    end
    total++; if (bus.out_k !== 5'd5) begin bad++; $display("FAIL rstmid pre k: got %0d want 5", bus.out_k); end
    #1 rst = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_k !== '0 || bus.out_last !== 1'b0) begin bad++; $display("FAIL rstmid outputs: got v=%b k=%0d l=%b nonzero_data=%b want 0", bus.out_valid, bus.out_k, bus.out_last, bus.out_data !== '0); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL rstmid after: got rdy=%b v=%b want 1/0", bus.in_ready, bus.out_valid); end
  endtask
`ifdef MMH_ROT_DIR_EN
  task automatic test_right;
    bus.data_in = '0; bus.data_in[1*SEG_W +: SEG_W] = 64'h1; bus.data_in[2*SEG_W +: SEG_W] = 64'h1;
    bus.k_count = 5'd2; dir = 1'b1; bus.in_valid = 1'b1;
    @(negedge clk); bus.in_valid = 1'b0; dir = 1'b0;
    total++; if (bus.out_data[1*PAD_W +: PAD_W] !== 192'h1) begin bad++; $display("FAIL right k0 seg1: got %h want 1", bus.out_data[1*PAD_W +: PAD_W]); end
    @(negedge clk);
    total++; if (bus.out_data[1*PAD_W +: PAD_W] !== (192'h1 << 180)) begin bad++; $display("FAIL right k1 seg1: got %h", bus.out_data[1*PAD_W +: PAD_W]); end
    total++; if (bus.out_data[2*PAD_W +: PAD_W] !== (192'h1 << 168)) begin bad++; $display("FAIL right k1 seg2: got %h", bus.out_data[2*PAD_W +: PAD_W]); end
    @(negedge clk);
  endtask
`endif
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end
  initial begin
    bus.in_valid = 1'b0; bus.data_in = '0; bus.k_count = '0; bus.out_ready = 1'b1;
    test_reset;
    test_single_bit;
    test_full_sweep;
    test_backpressure;
    test_back_to_back;
    test_flush;
    test_reset_mid;
`ifdef MMH_ROT_DIR_EN
    test_right;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
